// File: rtl/axis_eth_fcs_check_64.sv
// AXI-Stream Ethernet FCS checker, 64-bit datapath.
// Runs CRC-32 over every received byte, strips the trailing 4-byte FCS,
// and flags bad frames on the last output beat and with a status pulse.
// Output is delayed by one beat so that the FCS bytes can be trimmed off
// the tail before the last payload beat leaves.

module axis_eth_fcs_check_64 (
  input  logic        clk,
  input  logic        rst,

  input  logic [63:0] s_axis_tdata,
  input  logic [7:0]  s_axis_tkeep,
  input  logic        s_axis_tvalid,
  output logic        s_axis_tready,
  input  logic        s_axis_tlast,
  input  logic        s_axis_tuser,

  output logic [63:0] m_axis_tdata,
  output logic [7:0]  m_axis_tkeep,
  output logic        m_axis_tvalid,
  input  logic        m_axis_tready,
  output logic        m_axis_tlast,
  output logic        m_axis_tuser,

  output logic        status_error_bad_fcs
);

  localparam logic [31:0] CrcInit     = 32'hFFFF_FFFF;
  localparam logic [31:0] CrcResidue  = 32'hDEBB_20E3;
  // Reflected form of 32'h04C11DB7.
  localparam logic [31:0] CrcPolyRefl = 32'hEDB8_8320;

  typedef enum logic [1:0] {
    StIdle,  // hold register empty
    StHold,  // one full beat waiting in the hold register
    StTail   // trimmed last beat waiting for the output slot
  } state_e;

  state_e      state_q, state_d;
  logic [63:0] hold_data_q, hold_data_d;
  logic [63:0] tail_data_q, tail_data_d;
  logic [7:0]  tail_keep_q, tail_keep_d;
  logic        tail_user_q, tail_user_d;
  logic [31:0] crc_q, crc_d;

  logic [63:0] m_data_q, m_data_d;
  logic [7:0]  m_keep_q, m_keep_d;
  logic        m_valid_q, m_valid_d;
  logic        m_last_q, m_last_d;
  logic        m_user_q, m_user_d;
  logic        status_q, status_d;

  logic        out_free;
  logic        accept;
  logic [3:0]  beat_bytes;
  logic [31:0] crc_next;
  logic        fcs_bad;

  // Byte-serial reflected CRC over the first nbytes lanes; equivalent to the
  // 8/16/.../64-bit wide LFSR steps selected by the number of valid lanes.
  function automatic logic [31:0] crc_update(input logic [31:0] crc_in,
                                             input logic [63:0] data,
                                             input logic [3:0]  nbytes);
    logic [31:0] c;
    c = crc_in;
    for (int i = 0; i < 8; i++) begin
      if (i < int'(nbytes)) begin
        c = c ^ {24'h0, data[8*i +: 8]};
        for (int b = 0; b < 8; b++) begin
          c = c[0] ? ((c >> 1) ^ CrcPolyRefl) : (c >> 1);
        end
      end
    end
    return c;
  endfunction

  // tkeep is contiguous from lane 0, so the popcount is the byte count.
  function automatic logic [3:0] keep_count(input logic [7:0] keep);
    logic [3:0] n;
    n = '0;
    for (int i = 0; i < 8; i++) begin
      n = n + {3'b000, keep[i]};
    end
    return n;
  endfunction

  assign out_free      = !m_valid_q || m_axis_tready;
  assign s_axis_tready = out_free && (state_q != StTail);
  assign accept        = s_axis_tvalid && s_axis_tready;

  assign beat_bytes = s_axis_tlast ? keep_count(s_axis_tkeep) : 4'd8;
  assign crc_next   = crc_update(crc_q, s_axis_tdata, beat_bytes);
  assign fcs_bad    = (crc_next != CrcResidue);

  // Next-state, hold/tail staging and output-slot loading.
  always_comb begin
    state_d     = state_q;
    hold_data_d = hold_data_q;
    tail_data_d = tail_data_q;
    tail_keep_d = tail_keep_q;
    tail_user_d = tail_user_q;
    crc_d       = crc_q;
    m_data_d    = m_data_q;
    m_keep_d    = m_keep_q;
    m_valid_d   = m_valid_q && !m_axis_tready;
    m_last_d    = m_last_q;
    m_user_d    = m_user_q;
    status_d    = 1'b0;

    if (accept) begin
      crc_d = s_axis_tlast ? CrcInit : crc_next;
      unique case (state_q)
        StIdle: begin
          if (!s_axis_tlast) begin
            hold_data_d = s_axis_tdata;
            state_d     = StHold;
          end else if (beat_bytes >= 4'd5) begin
            // Single-beat frame: payload bytes sit in the low lanes.
            tail_data_d = s_axis_tdata;
            tail_keep_d = 8'hFF >> (4'd12 - beat_bytes);
            tail_user_d = s_axis_tuser || fcs_bad;
            status_d    = fcs_bad;
            state_d     = StTail;
          end else begin
            // Runt: no payload at all, pass one byte marked bad.
            m_data_d  = {56'h0, s_axis_tdata[7:0]};
            m_keep_d  = 8'h01;
            m_valid_d = 1'b1;
            m_last_d  = 1'b1;
            m_user_d  = 1'b1;
          end
        end
        StHold: begin
          m_data_d  = hold_data_q;
          m_valid_d = 1'b1;
          if (!s_axis_tlast) begin
            m_keep_d    = 8'hFF;
            m_last_d    = 1'b0;
            m_user_d    = 1'b0;
            hold_data_d = s_axis_tdata;
          end else if (beat_bytes <= 4'd4) begin
            // Whole last beat is FCS; the rest of it lives in the held beat.
            m_keep_d = 8'hFF >> (4'd4 - beat_bytes);
            m_last_d = 1'b1;
            m_user_d = s_axis_tuser || fcs_bad;
            status_d = fcs_bad;
            state_d  = StIdle;
          end else begin
            m_keep_d    = 8'hFF;
            m_last_d    = 1'b0;
            m_user_d    = 1'b0;
            tail_data_d = s_axis_tdata;
            tail_keep_d = 8'hFF >> (4'd12 - beat_bytes);
            tail_user_d = s_axis_tuser || fcs_bad;
            status_d    = fcs_bad;
            state_d     = StTail;
          end
        end
        default: ;
      endcase
    end else if (state_q == StTail && out_free) begin
      m_data_d  = tail_data_q;
      m_keep_d  = tail_keep_q;
      m_valid_d = 1'b1;
      m_last_d  = 1'b1;
      m_user_d  = tail_user_q;
      state_d   = StIdle;
    end
  end

  // State and datapath registers with synchronous reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= StIdle;
      hold_data_q <= '0;
      tail_data_q <= '0;
      tail_keep_q <= '0;
      tail_user_q <= 1'b0;
      crc_q       <= CrcInit;
      m_data_q    <= '0;
      m_keep_q    <= '0;
      m_valid_q   <= 1'b0;
      m_last_q    <= 1'b0;
      m_user_q    <= 1'b0;
      status_q    <= 1'b0;
    end else begin
      state_q     <= state_d;
      hold_data_q <= hold_data_d;
      tail_data_q <= tail_data_d;
      tail_keep_q <= tail_keep_d;
      tail_user_q <= tail_user_d;
      crc_q       <= crc_d;
      m_data_q    <= m_data_d;
      m_keep_q    <= m_keep_d;
      m_valid_q   <= m_valid_d;
      m_last_q    <= m_last_d;
      m_user_q    <= m_user_d;
      status_q    <= status_d;
    end
  end

  assign m_axis_tdata         = m_data_q;
  assign m_axis_tkeep         = m_keep_q;
  assign m_axis_tvalid        = m_valid_q;
  assign m_axis_tlast         = m_last_q;
  assign m_axis_tuser         = m_user_q;
  assign status_error_bad_fcs = status_q;

endmodule

// File: tb/tb_axis_eth_fcs_check_64.sv
// Bench for axis_eth_fcs_check_64: table of directed frames, a reset
// mid-frame sequence, back-to-back short frames, and randomized traffic
// with random backpressure checked against a frame-level reference model.

module tb_axis_eth_fcs_check_64;

  logic        clk = 1'b0;
  logic        rst;
  logic [63:0] s_axis_tdata;
  logic [7:0]  s_axis_tkeep;
  logic        s_axis_tvalid;
  logic        s_axis_tready;
  logic        s_axis_tlast;
  logic        s_axis_tuser;
  logic [63:0] m_axis_tdata;
  logic [7:0]  m_axis_tkeep;
  logic        m_axis_tvalid;
  logic        m_axis_tready;
  logic        m_axis_tlast;
  logic        m_axis_tuser;
  logic        status_error_bad_fcs;

  always #5 clk = ~clk;

  axis_eth_fcs_check_64 dut (
    .clk                  (clk),
    .rst                  (rst),
    .s_axis_tdata         (s_axis_tdata),
    .s_axis_tkeep         (s_axis_tkeep),
    .s_axis_tvalid        (s_axis_tvalid),
    .s_axis_tready        (s_axis_tready),
    .s_axis_tlast         (s_axis_tlast),
    .s_axis_tuser         (s_axis_tuser),
    .m_axis_tdata         (m_axis_tdata),
    .m_axis_tkeep         (m_axis_tkeep),
    .m_axis_tvalid        (m_axis_tvalid),
    .m_axis_tready        (m_axis_tready),
    .m_axis_tlast         (m_axis_tlast),
    .m_axis_tuser         (m_axis_tuser),
    .status_error_bad_fcs (status_error_bad_fcs)
  );

  int tests = 0;
  int fails = 0;

  logic [7:0] tx_q[$];
  logic [7:0] exp_bytes[$];
  logic [7:0] mon_bytes[$];
  logic [7:0] cur_q[$];
  int         exp_beats[$];
  int         mon_beats[$];
  logic [7:0] exp_keep[$];
  logic [7:0] mon_keep[$];
  logic       exp_user[$];
  logic       mon_user[$];
  int         exp_status = 0;
  int         status_cnt = 0;
  int         cur_beats  = 0;
  bit         rand_ready = 1'b0;
  bit         gaps       = 1'b0;

  bit          stall_pend = 1'b0;
  logic [74:0] stall_snap;

  typedef struct {
    int         len;    // bytes on the wire including FCS
    int         flip;   // byte index to corrupt after FCS, -1 for none
    bit         user;   // upstream error flag on last beat
    int         beats;  // expected output beats
    logic [7:0] keep;   // expected last-beat tkeep
    bit         ouser;  // expected last-beat tuser
    int         status; // expected status pulses
  } vec_t;

  vec_t vecs[10];

  task automatic check(input string name, input logic [95:0] got, input logic [95:0] exp);
    tests++;
    if (got !== exp) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h", name, got, exp);
    end
  endtask

  function automatic logic [31:0] crc_byte(input logic [31:0] c, input logic [7:0] d);
    logic [31:0] r;
    r = c ^ {24'h0, d};
    for (int b = 0; b < 8; b++) r = r[0] ? ((r >> 1) ^ 32'hEDB88320) : (r >> 1);
    return r;
  endfunction

  // Frame of len wire bytes; frames of 5+ bytes get a valid FCS appended.
  task automatic build_frame(input int len, input int flip);
    logic [31:0] c;
    logic [31:0] fcs;
    tx_q.delete();
    if (len <= 4) begin
      for (int i = 0; i < len; i++) tx_q.push_back(8'($urandom_range(0, 255)));
    end else begin
      c = 32'hFFFFFFFF;
      for (int i = 0; i < len - 4; i++) begin
        tx_q.push_back(8'($urandom_range(0, 255)));
        c = crc_byte(c, tx_q[i]);
      end
      fcs = ~c;
      for (int i = 0; i < 4; i++) tx_q.push_back(fcs[8*i +: 8]);
    end
    if (flip >= 0) tx_q[flip] = tx_q[flip] ^ 8'h01;
  endtask

  // Expected output for the frame in tx_q, from frame-level rules.
  task automatic model_frame(input bit user);
    int          n;
    int          p;
    int          nb;
    int          rem;
    logic [31:0] c;
    logic [31:0] got_fcs;
    logic [7:0]  k;
    bit          bad;
    n = tx_q.size();
    if (n <= 4) begin
      exp_bytes.push_back(tx_q[0]);
      exp_beats.push_back(1);
      exp_keep.push_back(8'h01);
      exp_user.push_back(1'b1);
    end else begin
      p = n - 4;
      c = 32'hFFFFFFFF;
      for (int i = 0; i < p; i++) c = crc_byte(c, tx_q[i]);
      got_fcs = {tx_q[n-1], tx_q[n-2], tx_q[n-3], tx_q[n-4]};
      bad = (got_fcs != ~c);
      for (int i = 0; i < p; i++) exp_bytes.push_back(tx_q[i]);
      nb  = (p + 7) / 8;
      rem = p - (nb - 1) * 8;
      k   = '0;
      for (int i = 0; i < rem; i++) k[i] = 1'b1;
      exp_beats.push_back(nb);
      exp_keep.push_back(k);
      exp_user.push_back(user | bad);
      if (bad) exp_status++;
    end
  endtask

  // Entered and left just after a rising edge.
  task automatic send_frame(input bit user, input int max_beats);
    int n;
    int nb;
    int t;
    bit hs;
    n  = tx_q.size();
    nb = (n + 7) / 8;
    for (int b = 0; b < nb && b < max_beats; b++) begin
      if (gaps && $urandom_range(0, 3) == 0) begin
        s_axis_tvalid = 1'b0;
        @(posedge clk); #1;
      end
      s_axis_tdata = '0;
      s_axis_tkeep = '0;
      for (int l = 0; l < 8; l++) begin
        if (b * 8 + l < n) begin
          s_axis_tdata[8*l +: 8] = tx_q[b*8+l];
          s_axis_tkeep[l] = 1'b1;
        end
      end
      s_axis_tlast  = (b == nb - 1);
      s_axis_tuser  = user;
      s_axis_tvalid = 1'b1;
      t  = 0;
      hs = 1'b0;
      while (!hs && t < 2000) begin
        @(negedge clk);
        hs = s_axis_tready;
        @(posedge clk); #1;
        t++;
      end
      if (!hs) begin
        tests++;
        fails++;
        $display("FAIL input_handshake: no tready after %0d cycles, required within 2000", t);
        break;
      end
    end
    s_axis_tvalid = 1'b0;
    s_axis_tlast  = 1'b0;
  endtask

  task automatic wait_frames(input int n, input int budget);
    int t;
    t = 0;
    while (mon_user.size() < n && t < budget) begin
      @(posedge clk); #1;
      t++;
    end
    repeat (4) begin
      @(posedge clk); #1;
    end
    check("frame_count", 96'(mon_user.size()), 96'(n));
  endtask

  task automatic compare_all(input string tag);
    int bad;
    int nb;
    int nf;
    bad = 0;
    check({tag, "_frames"}, 96'(mon_user.size()), 96'(exp_user.size()));
    check({tag, "_bytes"}, 96'(mon_bytes.size()), 96'(exp_bytes.size()));
    nb = (mon_bytes.size() < exp_bytes.size()) ? mon_bytes.size() : exp_bytes.size();
    for (int i = 0; i < nb; i++) if (mon_bytes[i] !== exp_bytes[i]) bad++;
    nf = (mon_user.size() < exp_user.size()) ? mon_user.size() : exp_user.size();
    for (int i = 0; i < nf; i++) begin
      if (mon_beats[i] != exp_beats[i] || mon_keep[i] !== exp_keep[i] ||
          mon_user[i] !== exp_user[i]) bad++;
    end
    check({tag, "_content_errors"}, 96'(bad), 96'(0));
    check({tag, "_status_pulses"}, 96'(status_cnt), 96'(exp_status));
    exp_bytes.delete(); mon_bytes.delete();
    exp_beats.delete(); mon_beats.delete();
    exp_keep.delete();  mon_keep.delete();
    exp_user.delete();  mon_user.delete();
    exp_status = 0;
    status_cnt = 0;
  endtask

  // Sink readiness, random when enabled.
  always @(posedge clk) begin
    #1;
    m_axis_tready = rand_ready ? ($urandom_range(0, 1) == 1) : 1'b1;
  end

  // Output monitor: sampled mid-cycle, a transfer completes at the next edge.
  always @(negedge clk) begin
    if (rst) begin
      cur_q.delete();
      cur_beats  = 0;
      stall_pend = 1'b0;
    end else begin
      if (stall_pend) begin
        check("stall_hold", 96'({m_axis_tvalid, m_axis_tdata, m_axis_tkeep, m_axis_tlast,
                                 m_axis_tuser}), 96'(stall_snap));
      end
      if (m_axis_tvalid && m_axis_tready) begin
        cur_beats++;
        for (int l = 0; l < 8; l++) if (m_axis_tkeep[l]) cur_q.push_back(m_axis_tdata[8*l +: 8]);
        if (m_axis_tlast) begin
          foreach (cur_q[i]) mon_bytes.push_back(cur_q[i]);
          mon_beats.push_back(cur_beats);
          mon_keep.push_back(m_axis_tkeep);
          mon_user.push_back(m_axis_tuser);
          cur_q.delete();
          cur_beats = 0;
        end
      end
      stall_pend = m_axis_tvalid && !m_axis_tready;
      stall_snap = {m_axis_tvalid, m_axis_tdata, m_axis_tkeep, m_axis_tlast, m_axis_tuser};
      if (status_error_bad_fcs) status_cnt++;
    end
  end

  initial begin
    #900000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int len;
    int flip;
    bit user;

    vecs[0] = '{64, -1, 1'b0, 8, 8'h0F, 1'b0, 0};
    vecs[1] = '{64, 10, 1'b0, 8, 8'h0F, 1'b1, 1};
    vecs[2] = '{65, -1, 1'b0, 8, 8'h1F, 1'b0, 0};
    vecs[3] = '{67, -1, 1'b0, 8, 8'h7F, 1'b0, 0};
    vecs[4] = '{64, -1, 1'b1, 8, 8'h0F, 1'b1, 0};
    vecs[5] = '{3,  -1, 1'b0, 1, 8'h01, 1'b1, 0};
    vecs[6] = '{8,  -1, 1'b0, 1, 8'h0F, 1'b0, 0};
    vecs[7] = '{12, -1, 1'b0, 1, 8'hFF, 1'b0, 0};
    vecs[8] = '{5,  -1, 1'b0, 1, 8'h01, 1'b0, 0};
    vecs[9] = '{13,  2, 1'b0, 2, 8'h01, 1'b1, 1};

    rst           = 1'b1;
    s_axis_tdata  = '0;
    s_axis_tkeep  = '0;
    s_axis_tvalid = 1'b0;
    s_axis_tlast  = 1'b0;
    s_axis_tuser  = 1'b0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    check("reset_m_tvalid", 96'(m_axis_tvalid), 96'(0));
    check("reset_m_tdata_tkeep", 96'({m_axis_tdata, m_axis_tkeep}), 96'(0));
    check("reset_m_tlast_tuser", 96'({m_axis_tlast, m_axis_tuser}), 96'(0));
    check("reset_status", 96'(status_error_bad_fcs), 96'(0));
    @(posedge clk); #1;
    rst = 1'b0;
    @(negedge clk);
    check("tready_after_reset", 96'(s_axis_tready), 96'(1));
    @(posedge clk); #1;

    // Directed table.
    for (int v = 0; v < 10; v++) begin
      build_frame(vecs[v].len, vecs[v].flip);
      model_frame(vecs[v].user);
      send_frame(vecs[v].user, 1000);
      wait_frames(1, 200);
      if (mon_user.size() >= 1) begin
        check($sformatf("vec%0d_beats", v), 96'(mon_beats[0]), 96'(vecs[v].beats));
        check($sformatf("vec%0d_keep", v), 96'(mon_keep[0]), 96'(vecs[v].keep));
        check($sformatf("vec%0d_tuser", v), 96'(mon_user[0]), 96'(vecs[v].ouser));
      end
      check($sformatf("vec%0d_status", v), 96'(status_cnt), 96'(vecs[v].status));
      compare_all($sformatf("vec%0d", v));
    end

    // Back-to-back single-beat frames, each passing through the tail stage.
    for (int i = 0; i < 3; i++) begin
      build_frame(6 + i, (i == 1) ? 0 : -1);
      model_frame(1'b0);
      send_frame(1'b0, 1000);
    end
    wait_frames(3, 200);
    compare_all("b2b");

    // Reset after beat 3 of a 10-beat frame; only the next frame may appear.
    build_frame(80, -1);
    send_frame(1'b0, 3);
    rst = 1'b1;
    repeat (2) begin
      @(posedge clk); #1;
    end
    rst = 1'b0;
    @(negedge clk);
    check("rst_mid_tready", 96'(s_axis_tready), 96'(1));
    check("rst_mid_m_tvalid", 96'(m_axis_tvalid), 96'(0));
    @(posedge clk); #1;
    exp_status = 0;
    status_cnt = 0;
    build_frame(64, -1);
    model_frame(1'b0);
    send_frame(1'b0, 1000);
    wait_frames(1, 200);
    compare_all("rst_mid");

    // Randomized traffic with random sink stalls and source gaps.
    gaps       = 1'b1;
    rand_ready = 1'b1;
    for (int f = 0; f < 100; f++) begin
      len  = $urandom_range(1, 140);
      flip = ($urandom_range(0, 3) == 0) ? $urandom_range(0, len - 1) : -1;
      user = ($urandom_range(0, 7) == 0);
      build_frame(len, flip);
      model_frame(user);
      send_frame(user, 1000);
    end
    wait_frames(100, 20000);
    rand_ready = 1'b0;
    gaps       = 1'b0;
    compare_all("random");

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/axis_eth_fcs_check_64.md
AXIS_ETH_FCS_CHECK_64 -- requirements
Module: axis_eth_fcs_check_64

Interface
REQ-001 Parameters: none; datapath fixed at 64 bits / 8 byte lanes, lane 0 = first byte on the wire.
REQ-002 clk  input  1  single clock; all logic on rising edge.
REQ-003 rst  input  1  reset, synchronous, active-high.
REQ-004 s_axis_tdata  input  64  frame bytes including trailing 4-byte FCS.
REQ-005 s_axis_tkeep  input  8  byte enables; all ones on non-last beats, contiguous from lane 0 on the last beat.
REQ-006 s_axis_tvalid  input  1 / s_axis_tready  output  1 / s_axis_tlast  input  1 / s_axis_tuser  input  1 (upstream error flag, sampled on the last beat).
REQ-007 m_axis_tdata  output  64 / m_axis_tkeep  output  8 / m_axis_tvalid  output  1 / m_axis_tready  input  1 / m_axis_tlast  output  1 / m_axis_tuser  output  1: frame with FCS removed; tuser=1 on the last beat marks a bad frame.
REQ-008 status_error_bad_fcs  output  1  one-cycle pulse per frame whose FCS fails.

Function
REQ-009 CRC-32: polynomial 32'h04C11DB7, reflected, Galois form, state init 32'hFFFFFFFF, computed with the codebase lfsr module in 8/16/.../64-bit widths selected by last-beat tkeep.
REQ-010 CRC runs over every input byte including the FCS; the frame passes iff the final state equals 32'hDEBB20E3.
REQ-011 CRC state returns to 32'hFFFFFFFF after each accepted last beat.
REQ-012 Transfer occurs only when tvalid && tready on the same edge.
REQ-013 Input is delayed by one beat in a hold register; a beat is emitted only once the next beat, or the last beat, has arrived.
REQ-014 Outputs are registered; m_axis_* hold stable while m_axis_tvalid=1 && m_axis_tready=0.
REQ-015 s_axis_tready = (m_axis_tvalid=0 || m_axis_tready=1) && state!=TAIL.
REQ-016 States: IDLE (hold empty), HOLD (hold register full), TAIL (stored trimmed last beat pending).
REQ-017 IDLE: non-last beat accepted -> store in hold, go HOLD, no output.
REQ-018 HOLD, non-last beat accepted -> emit held beat (tkeep 8'hFF, tlast 0), store new beat, stay HOLD.
REQ-019 HOLD, last beat with k valid bytes, k<=4 -> emit held beat with tlast=1, tkeep = 8'hFF>>(4-k) (k=1:8'h1F, 2:8'h3F, 3:8'h7F, 4:8'hFF), tuser per REQ-022, go IDLE.
REQ-020 HOLD, last beat with k>=5 -> emit held beat (tlast 0), store last beat with tkeep = 8'hFF>>(12-k) (k=5:8'h01 ... k=8:8'h0F), go TAIL.
REQ-021 TAIL: s_axis_tready=0; when the output slot frees, emit stored beat with tlast=1, tuser per REQ-022, go IDLE.
REQ-022 Last output beat tuser = s_axis_tuser(last beat) OR FCS mismatch.
REQ-023 IDLE, last beat, k>=5 (single-beat frame) -> go TAIL with tkeep per REQ-020.
REQ-024 IDLE, last beat, k<=4 (runt, no payload) -> emit one beat: byte 0 of input, tkeep 8'h01, tlast 1, tuser 1; status_error_bad_fcs not pulsed.
REQ-025 status_error_bad_fcs pulses on the cycle after the last input beat is accepted iff the CRC check fails (runts excluded); upstream tuser alone does not pulse it.
REQ-026 Frames are back-to-back capable; a new frame may start the cycle after TAIL empties.

Reset
REQ-027 On rst: state IDLE, hold and tail registers invalid, CRC state 32'hFFFFFFFF, m_axis_tvalid 0, m_axis_tlast 0, m_axis_tuser 0, m_axis_tkeep 0, m_axis_tdata 0, status_error_bad_fcs 0.
REQ-028 Reset mid-frame discards the partial frame; no trailing beat is emitted after reset, and s_axis_tready=1 in the cycle after reset deasserts.

Verification
REQ-029 64-byte frame (60 payload + correct FCS, 8 beats, last tkeep 8'hFF), m_axis_tready=1 -> 8 output beats, last tkeep 8'h0F, tuser 0, no status pulse.
REQ-030 Same frame with payload byte 10 XOR 8'h01 -> identical length/tkeep, last tuser 1, status_error_bad_fcs pulses once.
REQ-031 65-byte frame with correct FCS (last input tkeep 8'h01) -> 8 output beats, last tkeep 8'h1F, tuser 0; 67-byte frame -> last tkeep 8'h7F.
REQ-032 Correct-FCS frame with s_axis_tuser=1 on the last beat -> last output tuser 1, no status pulse; a 3-byte runt -> single beat tkeep 8'h01, tuser 1.
REQ-033 Random m_axis_tready (50%) over 100 mixed-length frames -> output byte stream equals input minus FCS, no beat lost or duplicated, outputs stable while stalled.
REQ-034 rst asserted after beat 3 of a 10-beat frame, next frame sent after release -> only the next frame appears on the output, checked correctly.
